// File: rtl/fetch_unit.sv
// fetch_unit -- LITE-16 instruction fetch stage.
//
// Owns the program counter and reads one instruction word at a time from
// instruction memory over a req/ready handshake. It buffers the returned word
// and hands it to the instruction register with a one-cycle load strobe.
// Jumps and branches redirect the fetch stream. Halt parks the unit until the
// next redirect.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   mem_req/mem_addr    read request and word address to instruction memory
//   mem_ready/mem_rdata memory returns the word this cycle
//   ir_data/ir_en       word and load strobe to the instruction register
//   decode_ready        downstream can accept an instruction this cycle
//   redirect/redirect_pc  taken jump/branch and its target
//   halt                stop fetching after the current handoff
//   pc                  address of the last delivered instruction
//   busy                unit is in REQ or DELIVER
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir_data,
  output logic        ir_en,
  input  logic        decode_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DELIVER = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] pc_q, pc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      buf_q      <= 16'h0000;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      buf_q      <= buf_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    buf_d      = buf_q;
    pc_d       = pc_q;
    mem_req    = 1'b0;
    ir_en      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        // A redirect kills the handoff in the same cycle it arrives.
        ir_en = decode_ready & ~redirect;
        if (ir_en) begin
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = halt ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase

    // Redirect beats everything except the post-reset IDLE cycle: restart
    // fetch at the target and drop any word returning this cycle.
    if (redirect && state_q != S_IDLE) begin
      fetch_pc_d = redirect_pc;
      buf_d      = buf_q;
      state_d    = S_REQ;
    end
  end

  assign mem_addr = fetch_pc_q;
  assign ir_data  = buf_q;
  assign pc       = pc_q;
  assign busy     = (state_q == S_REQ) || (state_q == S_DELIVER);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the LITE-16 core, directly upstream of the instruction register. Owns the program counter, issues word reads to instruction memory over a request/ready handshake, buffers the returned word, and delivers it to the instruction register through its `data_in`/`en` pair. Supports redirect for jumps and branches, and halt.

## Interface
- `RESET_PC`, default 16'h0000: fetch address after reset.
- `PC_STEP`, default 16'h0001: PC increment per instruction (word addressing).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  16  read address; valid while `mem_req`=1.
- `mem_ready`  in  1  memory returns `mem_rdata` this cycle.
- `mem_rdata`  in  16  instruction word.
- `ir_data`  out  16  instruction word to the instruction register `data_in`.
- `ir_en`  out  1  load strobe to the instruction register `en`.
- `decode_ready`  in  1  downstream accepts a new instruction this cycle.
- `redirect`  in  1  jump/branch taken; discard in-flight work.
- `redirect_pc`  in  16  new fetch address, sampled when `redirect`=1.
- `halt`  in  1  stop fetching after the current delivery.
- `pc`  out  16  address of the last delivered instruction.
- `busy`  out  1  1 in any state except IDLE and HALTED.

## Operation
- Internal regs: `fetch_pc[15:0]`, `buf[15:0]` (drives `ir_data`), `pc[15:0]`, and state.
- FSM states: IDLE, REQ, DELIVER, HALTED.
- IDLE: entered only from reset. `mem_req`=0. Goes to REQ unconditionally on the next edge.
- REQ: `mem_req`=1, `mem_addr`=`fetch_pc`. On an edge with `mem_ready`=1: `buf`<=`mem_rdata`, go to DELIVER. Otherwise stay and hold the address stable.
- DELIVER: `mem_req`=0. `ir_en` = `decode_ready` & ~`redirect`, combinational. On an edge with `ir_en`=1: `pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+`PC_STEP` (mod 2^16). Next state is HALTED if `halt`=1, else REQ. If `decode_ready`=0, stay in DELIVER and hold `buf`.
- HALTED: `mem_req`=0, `ir_en`=0. Only `redirect` exits this state.
- Redirect has the highest priority, in every state except IDLE. On an edge with `redirect`=1: `fetch_pc`<=`redirect_pc`, next state is REQ. A `mem_rdata` returned in the same cycle is discarded. The `buf` contents are never delivered. `pc` is unchanged.
- `halt` is ignored outside DELIVER, and in DELIVER it is ignored unless the handoff occurs.
- `mem_addr` is driven as `fetch_pc` in all states. It is meaningful only while `mem_req`=1.

## Timing
- Reset (`rst`=0) takes effect immediately, independent of `clk`:
  - state=IDLE, `fetch_pc`=`RESET_PC`, `pc`=`RESET_PC`, `buf`=0.
  - Outputs: `mem_req`=0, `mem_addr`=`RESET_PC`, `ir_data`=0, `ir_en`=0, `busy`=0.
- Reset asserted mid-transaction aborts the transaction. No `ir_en` pulse is produced.
- First `mem_req` is asserted in the cycle after the first rising edge following reset release.
- Best-case throughput is one instruction per 2 cycles (REQ, DELIVER), with `mem_ready` and `decode_ready` both high.
- `ir_en` is high for exactly one cycle per delivered instruction. The instruction register holds the word from the following edge.
- `mem_req` stays high, with a stable `mem_addr`, until `mem_ready` is sampled high. `mem_ready` sampled while `mem_req`=0 is ignored.
- PC wrap: `fetch_pc`=16'hFFFF with `PC_STEP`=1 advances to 16'h0000, with no flag.
- Simultaneous `redirect` and `decode_ready` in DELIVER: `ir_en`=0 and the redirect wins.
- Simultaneous `halt` and `redirect` in DELIVER: the redirect wins and the next state is REQ.

## Test plan
- **Reset, zero wait states:** release reset with `mem_ready`=1, `decode_ready`=1, memory returning addr+16'h1000. Required: `mem_addr` 0,1,2 issued; `ir_en` pulses every 2nd cycle with `ir_data` 1000,1001,1002; `pc` 0,1,2.
- **Memory wait:** hold `mem_ready`=0 for 3 cycles in REQ. Required: `mem_req`=1 and `mem_addr` stable for 4 cycles; exactly one `ir_en`.
- **Decode stall:** `decode_ready`=0 for 5 cycles in DELIVER. Required: `ir_en`=0 throughout; `buf` held; one pulse when `decode_ready` rises; no new `mem_req` until then.
- **Redirect:**
  - Pulse `redirect` with `redirect_pc`=16'h0040 while in REQ, with `mem_ready`=1 in the same cycle. Required: that word is never delivered; next `mem_addr`=0040.
  - Repeat while in DELIVER with `decode_ready`=1. Required: no `ir_en`.
- **Halt and wrap:**
  - Redirect to 16'hFFFF, then assert `halt` at that delivery. Required: one `ir_en` with `pc`=FFFF; HALTED with `mem_req`=0 and `busy`=0; `fetch_pc`=0000.
  - A later `redirect` to 16'h0000 resumes fetching from 0000.
- **Async reset mid-fetch:** assert `rst`=0 between edges during DELIVER. Required: outputs reach their reset values before the next edge; no `ir_en`.
